// File: rtl/tile_state_ctrl.sv
// Playfield tile-state RAM with scan-tracking tile counters and a single shared port
// arbitrated between display reads, a bulk clear sequencer and one game-logic writer.
module tile_state_ctrl #(
  parameter int TILE_PX  = 30,
  parameter int X_OFFSET = 80,
  parameter int H_TOTAL  = 800,
  parameter int V_TOTAL  = 525,
  parameter int STATE_W  = 4
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               pix_en,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  output logic               pix_valid,
  output logic               in_field,
  output logic [STATE_W-1:0] tile_state,
  output logic [9:0]         rom_addr,
  input  logic               wr_req,
  input  logic [3:0]         wr_tile_x,
  input  logic [3:0]         wr_tile_y,
  input  logic [STATE_W-1:0] wr_state,
  output logic               wr_ack,
  input  logic               clr_req,
  output logic               busy
);

  localparam int FIELD_PX = 16 * TILE_PX;

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} clr_state_t;

  clr_state_t         state_r, state_s;
  logic [7:0]         clr_idx_r, clr_idx_s;
  logic [3:0]         tx_r, ty_r;
  logic [4:0]         subx_r, suby_r;
  logic [STATE_W-1:0] ram_r [0:255];
  logic               clr_grant_s, wr_grant_s, in_field_s;
  logic [9:0]         rom_addr_s;

  // Port arbitration: the display read always owns a pix_en cycle; the clear beats the writer.
  always_comb begin
    clr_grant_s = 1'b0;
    wr_grant_s  = 1'b0;
    if (Reset || pix_en) begin
      clr_grant_s = 1'b0;
      wr_grant_s  = 1'b0;
    end else if (state_r == CLEAR) begin
      clr_grant_s = 1'b1;
    end else if (wr_req) begin
      wr_grant_s = 1'b1;
    end else begin
      wr_grant_s = 1'b0;
    end
  end

  assign wr_ack = wr_grant_s;
  assign busy   = (state_r == CLEAR);

  // Clear sequencer next state; a new clr_req always restarts the sweep from tile 0.
  always_comb begin
    state_s   = state_r;
    clr_idx_s = clr_idx_r;
    if (clr_req) begin
      state_s   = CLEAR;
      clr_idx_s = 8'd0;
    end else if (clr_grant_s) begin
      clr_idx_s = clr_idx_r + 8'd1;
      if (clr_idx_r == 8'd255) begin
        state_s = IDLE;
      end else begin
        state_s = CLEAR;
      end
    end else begin
      state_s   = state_r;
      clr_idx_s = clr_idx_r;
    end
  end

  // Clear sequencer state register; reset enters CLEAR so stale RAM is never shown.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r   <= CLEAR;
      clr_idx_r <= 8'd0;
    end else begin
      state_r   <= state_s;
      clr_idx_r <= clr_idx_s;
    end
  end

  // RAM write port, shared by the clear sweep and the game-logic writer.
  always_ff @(posedge Clk) begin
    if (clr_grant_s) begin
      ram_r[clr_idx_r] <= '0;
    end else if (wr_grant_s) begin
      ram_r[{wr_tile_y, wr_tile_x}] <= wr_state;
    end
  end

  // Tile counters describe the pixel on DrawX/DrawY; updates prepare the next pixel.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      tx_r   <= 4'd0;
      subx_r <= 5'd0;
      ty_r   <= 4'd0;
      suby_r <= 5'd0;
    end else if (pix_en) begin
      if (DrawX == 10'(X_OFFSET - 1)) begin
        tx_r   <= 4'd0;
        subx_r <= 5'd0;
      end else if (subx_r == 5'(TILE_PX - 1)) begin
        tx_r   <= tx_r + 4'd1;
        subx_r <= 5'd0;
      end else begin
        subx_r <= subx_r + 5'd1;
      end
      if (DrawX == 10'(H_TOTAL - 1)) begin
        if (DrawY == 10'(V_TOTAL - 1)) begin
          ty_r   <= 4'd0;
          suby_r <= 5'd0;
        end else if (suby_r == 5'(TILE_PX - 1)) begin
          ty_r   <= ty_r + 4'd1;
          suby_r <= 5'd0;
        end else begin
          suby_r <= suby_r + 5'd1;
        end
      end
    end
  end

  // Field test and suby*30+subx using shifts only.
  always_comb begin
    in_field_s = (DrawX >= 10'(X_OFFSET)) && (DrawX < 10'(X_OFFSET + FIELD_PX)) &&
                 (DrawY < 10'(FIELD_PX));
    rom_addr_s = ({5'd0, suby_r} << 5) - ({5'd0, suby_r} << 1) + {5'd0, subx_r};
  end

  // Display read and output registers; outputs hold between strobes.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pix_valid  <= 1'b0;
      in_field   <= 1'b0;
      tile_state <= '0;
      rom_addr   <= 10'd0;
    end else if (pix_en) begin
      pix_valid  <= 1'b1;
      in_field   <= in_field_s;
      tile_state <= in_field_s ? ram_r[{ty_r, tx_r}] : '0;
      rom_addr   <= in_field_s ? rom_addr_s : 10'd0;
    end else begin
      pix_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tile_state_ctrl.sv
// Scoreboard bench for tile_state_ctrl: strobes push expected pixels, a monitor pops them
// on pix_valid; write/clear handshakes are checked against a tile model.
module tb_tile_state_ctrl;

  logic       Clk = 1'b0;
  logic       Reset, pix_en, wr_req, clr_req;
  logic [9:0] DrawX, DrawY;
  logic [3:0] wr_tile_x, wr_tile_y, wr_state;
  logic       pix_valid, in_field, wr_ack, busy;
  logic [3:0] tile_state;
  logic [9:0] rom_addr;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       inf;
    logic [3:0] st;
    logic [9:0] rom;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [3:0] model [16][16];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         ack_cnt  = 0;

  tile_state_ctrl dut (
    .Clk(Clk), .Reset(Reset), .pix_en(pix_en), .DrawX(DrawX), .DrawY(DrawY),
    .pix_valid(pix_valid), .in_field(in_field), .tile_state(tile_state), .rom_addr(rom_addr),
    .wr_req(wr_req), .wr_tile_x(wr_tile_x), .wr_tile_y(wr_tile_y), .wr_state(wr_state),
    .wr_ack(wr_ack), .clr_req(clr_req), .busy(busy)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic exp_t expect_px(input int x, input int y);
    exp_t e;
    e   = '0;
    e.x = 10'(x);
    e.y = 10'(y);
    if (x >= 80 && x < 560 && y < 480) begin
      e.inf = 1'b1;
      e.st  = model[y / 30][(x - 80) / 30];
      e.rom = 10'(((y % 30) * 30) + ((x - 80) % 30));
    end
    return e;
  endfunction

  // One pixel strobe followed by an idle cycle, so pix_en runs every other cycle.
  task automatic strobe(input int x, input int y);
    DrawX  = 10'(x);
    DrawY  = 10'(y);
    pix_en = 1'b1;
    exp_q.push_back(expect_px(x, y));
    @(posedge Clk); #1;
    pix_en = 1'b0;
    @(posedge Clk); #1;
  endtask

  function automatic bit line_sel(input int y, input int mode);
    if (mode == 0) return (y % 30 == 15) && (y < 480);
    return ((y % 30 == 0) && (y < 480)) || y == 179 || y == 479 || y == 480 || y == 524;
  endfunction

  task automatic scan_frame(input int mode);
    for (int y = 0; y < 525; y++) begin
      if (line_sel(y, mode)) begin
        for (int x = 79; x <= 560; x++) strobe(x, y);
      end
      strobe(799, y);
    end
  endtask

  task automatic do_write(input logic [3:0] x, input logic [3:0] y, input logic [3:0] s,
                          input bit pulse_clr, input int bound, output int waited);
    int acks0;
    int iter;
    bit got;
    acks0     = ack_cnt;
    got       = 1'b0;
    waited    = 0;
    iter      = 0;
    wr_tile_x = x;
    wr_tile_y = y;
    wr_state  = s;
    wr_req    = 1'b1;
    if (pulse_clr) clr_req = 1'b1;
    while (!got && waited < bound) begin
      @(negedge Clk);
      iter++;
      if (iter == 2) clr_req = 1'b0;
      if (wr_ack) got = 1'b1;
      else waited++;
    end
    clr_req = 1'b0;
    @(posedge Clk); #1;
    wr_req = 1'b0;
    check("wr_ack_seen", 32'(got), 32'd1);
    if (got) model[y][x] = s;
    repeat (2) @(posedge Clk);
    #1;
    check("one_ack_per_req", 32'(ack_cnt - acks0), 32'd1);
  endtask

  task automatic write_toggling(input logic [3:0] x, input logic [3:0] y, input logic [3:0] s,
                                input bit offset);
    int w;
    fork
      for (int i = 0; i < 5; i++) strobe(0, 490);
      begin
        if (offset) begin
          @(posedge Clk); #1;
        end
        do_write(x, y, s, 1'b0, 20, w);
        check("wr_latency", 32'(w), offset ? 32'd0 : 32'd1);
      end
    join
  endtask

  // Monitor: pops the scoreboard on every pix_valid and polices every wr_ack.
  always @(negedge Clk) begin
    if (!Reset) begin
      if (pix_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pix_valid", 32'(exp_q.size()), 32'd1);
        end else begin
          mon_e = exp_q.pop_front();
          check($sformatf("in_field(%0d,%0d)", mon_e.x, mon_e.y), 32'(in_field), 32'(mon_e.inf));
          check($sformatf("tile_state(%0d,%0d)", mon_e.x, mon_e.y), 32'(tile_state), 32'(mon_e.st));
          check($sformatf("rom_addr(%0d,%0d)", mon_e.x, mon_e.y), 32'(rom_addr), 32'(mon_e.rom));
        end
      end
      if (wr_ack) begin
        ack_cnt++;
        check("ack_without_pix_en", 32'(pix_en), 32'd0);
        check("ack_while_not_busy", 32'(busy), 32'd0);
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: actual still running, required finished");
    $fatal(1);
  end

  initial begin
    int bcnt;
    int w;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) model[i][j] = 4'd0;
    Reset = 1'b1; pix_en = 1'b0; wr_req = 1'b0; clr_req = 1'b0;
    DrawX = 10'd0; DrawY = 10'd0; wr_tile_x = 4'd0; wr_tile_y = 4'd0; wr_state = 4'd0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("reset_pix_valid", 32'(pix_valid), 32'd0);
    check("reset_in_field", 32'(in_field), 32'd0);
    check("reset_tile_state", 32'(tile_state), 32'd0);
    check("reset_rom_addr", 32'(rom_addr), 32'd0);
    check("reset_wr_ack", 32'(wr_ack), 32'd0);
    check("reset_busy", 32'(busy), 32'd1);

    // Power-up clear with pix_en every other cycle.
    @(posedge Clk); #1;
    Reset = 1'b0;
    bcnt  = 0;
    fork
      for (int i = 0; i < 300; i++) strobe(0, 490);
      repeat (600) begin
        @(negedge Clk);
        if (busy) bcnt++;
      end
    join
    check("clear_busy_cycles", 32'(bcnt), 32'd512);
    check("busy_after_clear", 32'(busy), 32'd0);

    scan_frame(0);

    write_toggling(4'd3, 4'd5, 4'hA, 1'b1);
    write_toggling(4'd0, 4'd0, 4'h1, 1'b0);
    write_toggling(4'd15, 4'd15, 4'hF, 1'b1);
    write_toggling(4'd15, 4'd0, 4'h7, 1'b0);

    scan_frame(1);

    // Clear request raced with a pending write: the write must land after the sweep.
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) model[i][j] = 4'd0;
    fork
      for (int i = 0; i < 300; i++) strobe(0, 490);
      begin
        do_write(4'd7, 4'd8, 4'h5, 1'b1, 1000, w);
        check("clr_blocks_wr_cycles", 32'(w), 32'd513);
      end
    join
    check("busy_after_reclear", 32'(busy), 32'd0);

    scan_frame(0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tile_state_ctrl.md
# tile_state_ctrl

Owns the 16×16 tile-state RAM for the playfield and sequences per-pixel tile lookups for the color mapper. Tracks the VGA scan with tile counters, so no divider or multiplier-by-variable is needed, and presents the tile state plus background-ROM read address one cycle after each pixel strobe. Shares the single RAM port between the display scan (highest priority), a bulk clear sequencer, and one game-logic write requester using a req/ack handshake.

## Interface
- TILE_PX, 30, tile edge in pixels
- X_OFFSET, 80, first playfield column (DrawX)
- H_TOTAL, 800, DrawX values per line, including blanking
- V_TOTAL, 525, DrawY values per frame, including blanking
- STATE_W, 4, tile-state width in bits

- Clk  in  1  system clock; the only clock
- Reset  in  1  synchronous, active-high
- pix_en  in  1  one-cycle pixel strobe; never asserted on consecutive cycles
- DrawX, DrawY  in  10 each  current scan pixel, sampled on pix_en
- pix_valid  out  1  one-cycle pulse; other display outputs are valid with it
- in_field  out  1  pixel lies inside the 480×480 playfield
- tile_state  out  STATE_W  state of the tile under the pixel
- rom_addr  out  10  pixel offset inside the tile: suby*30+subx, range 0..899
- wr_req  in  1  game-logic write request; held until wr_ack
- wr_tile_x, wr_tile_y  in  4 each  target tile
- wr_state  in  STATE_W  value to write
- wr_ack  out  1  one-cycle pulse; the write committed in this cycle
- clr_req  in  1  pulse; start a bulk clear of all tiles to 0
- busy  out  1  clear in progress

## Operation
- Counters: tx/subx (4/5 bits), ty/suby (4/5 bits). All advance only on pix_en.
- X update on pix_en:
  - DrawX==X_OFFSET-1 → tx, subx ← 0.
  - else subx==TILE_PX-1 → subx ← 0, tx ← tx+1 (wraps mod 16).
  - else subx ← subx+1.
- Y update on pix_en with DrawX==H_TOTAL-1:
  - DrawY==V_TOTAL-1 → ty, suby ← 0.
  - else suby==TILE_PX-1 → suby ← 0, ty ← ty+1.
  - else suby ← suby+1.
- These rules make the counters describe the pixel currently on DrawX/DrawY, given DrawX steps by 1 per pix_en.
- in_field = (X_OFFSET ≤ DrawX < X_OFFSET+480) && (DrawY < 480).
- RAM: 256×STATE_W, address {ty,tx} for reads and {wr_tile_y,wr_tile_x} for writes. Single port, synchronous read.
- Port priority per cycle:
  1. pix_en: display read.
  2. Clear FSM in CLEAR: write 0 to clr_idx.
  3. wr_req: write, assert wr_ack.
  - Only one access per cycle.
- Clear FSM has two states, IDLE and CLEAR.
  - IDLE → CLEAR on clr_req; clr_idx ← 0.
  - In CLEAR, clr_idx increments on each granted clear write.
  - After the write at index 255, the FSM returns to IDLE.
  - clr_req while in CLEAR restarts clr_idx at 0.
- busy = (state==CLEAR).
- wr_req is never acked while busy; it stays pending.
- rom_addr arithmetic: suby*30 = (suby<<5)-(suby<<1), plus subx, computed at 10 bits with no overflow.
- Outside the field, tile_state and rom_addr are forced to 0. in_field is still reported.

## Timing
- Reset values:
  - pix_valid, in_field, tile_state, rom_addr, wr_ack = 0.
  - All counters = 0.
  - FSM = CLEAR with clr_idx=0, so busy=1 during and after Reset. Power-up RAM contents are therefore never displayed as valid game state.
- Display latency: pix_en at cycle N → pix_valid=1 at N+1 with that pixel's in_field, tile_state and rom_addr. Outputs hold until the next pix_valid.
- A write committed at cycle k is visible to any pix_en read at cycle >k.
- wr_ack comes 0 cycles after grant: it is asserted in the commit cycle.
  - Earliest ack: the first non-pix_en, non-busy cycle in which wr_req is high.
  - Requester deasserts wr_req, or presents the next request, in the following cycle.
  - A write to the same tile as a concurrent read cannot occur, because the read has the port.
- Clear duration is 256 non-pix_en cycles, i.e. 512 Clk at pix_en every other cycle. busy falls the cycle after the index-255 write.
- Reset mid-clear or mid-request restarts the clear from 0 and drops any pending ack.

## Test plan
- Release Reset with pix_en toggling every other cycle → busy=1 for 512 cycles, then 0. A full-frame scan then shows tile_state=0 at all 256 tiles.
- After clear, write tile (3,5)=4'hA, then scan the frame → tile_state=A exactly for DrawX 170..199 and DrawY 150..179. rom_addr=0 at (170,150) and 899 at (199,179).
- Hold wr_req with pix_en every other cycle → wr_ack lands only on non-pix_en cycles. One write per request.
- Assert clr_req while wr_req is pending → no wr_ack until busy falls. The pending write then commits and survives the clear.
- Boundary pixels: DrawX=79/560 and DrawY=480 → in_field=0, tile_state=0, rom_addr=0. At DrawX=80, DrawY=0 → tx=ty=0 and rom_addr=0. The frame wrap from DrawY=524 → row 0 is correct on the next frame.
